// File: rtl/mprj_wb_pkg.sv
// ============================================================================
// Module      : mprj_wb_pkg
// Description : Shared types and constants for the user-project Wishbone guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mprj_wb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [DAT_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mprj_wb_tmo_cnt.sv
// ============================================================================
// Module      : mprj_wb_tmo_cnt
// Description : Clearable up-counter with terminal-count flag at TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mprj_wb_tmo_cnt #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/mprj_wb_guard.sv
// ============================================================================
// Module      : mprj_wb_guard
// Description : Registered Wishbone bridge to the user project with enable
//               isolation and no-ack timeout. Optional statistics outputs are
//               built when MPRJ_WB_GUARD_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mprj_wb_guard
  import mprj_wb_pkg::*;
#(
  parameter int unsigned       TIMEOUT      = 1024,
  parameter logic [DAT_W-1:0]  TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             mprj_wb_iena,
  input  logic             mprj_cyc_o,
  input  logic             mprj_stb_o,
  input  logic             mprj_we_o,
  input  logic [SEL_W-1:0] mprj_sel_o,
  input  logic [ADR_W-1:0] mprj_adr_o,
  input  logic [DAT_W-1:0] mprj_dat_o,
  output logic             mprj_ack_i,
  output logic [DAT_W-1:0] mprj_dat_i,
  output logic             usr_cyc_o,
  output logic             usr_stb_o,
  output logic             usr_we_o,
  output logic [SEL_W-1:0] usr_sel_o,
  output logic [ADR_W-1:0] usr_adr_o,
  output logic [DAT_W-1:0] usr_dat_o,
  input  logic             usr_ack_i,
  input  logic [DAT_W-1:0] usr_dat_i,
  output logic             timeout_flag
`ifdef MPRJ_WB_GUARD_STATS_EN
  ,
  output logic [15:0]      timeout_count,
  output logic [ADR_W-1:0] last_timeout_adr
`endif
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e           state_q,   state_d;
  logic             usr_cyc_q, usr_cyc_d;
  logic             usr_we_q,  usr_we_d;
  logic [SEL_W-1:0] usr_sel_q, usr_sel_d;
  logic [ADR_W-1:0] usr_adr_q, usr_adr_d;
  logic [DAT_W-1:0] usr_dat_q, usr_dat_d;
  logic             ack_q,     ack_d;
  logic [DAT_W-1:0] rdat_q,    rdat_d;
  logic             flag_q,    flag_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             tmo_tc;

  mprj_wb_tmo_cnt #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_tmo_cnt (
    .clk_i  (core_clk),
    .rst_ni (core_rstn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    usr_cyc_d = usr_cyc_q;
    usr_we_d  = usr_we_q;
    usr_sel_d = usr_sel_q;
    usr_adr_d = usr_adr_q;
    usr_dat_d = usr_dat_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    flag_d    = flag_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mprj_cyc_o && mprj_stb_o) begin
          if (mprj_wb_iena) begin
            usr_we_d  = mprj_we_o;
            usr_sel_d = mprj_sel_o;
            usr_adr_d = mprj_adr_o;
            usr_dat_d = mprj_dat_o;
            usr_cyc_d = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = ST_REQ;
          end else begin
            // Disabled interface: answer locally so the core never stalls.
            rdat_d  = '0;
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_REQ: begin
        cnt_en = 1'b1;
        if (!mprj_cyc_o) begin
          usr_cyc_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (usr_ack_i) begin
          // A user ack coincident with terminal count still wins.
          rdat_d    = usr_dat_i;
          usr_cyc_d = 1'b0;
          ack_d     = 1'b1;
          state_d   = ST_RESP;
        end else if (tmo_tc) begin
          rdat_d    = TIMEOUT_DATA;
          usr_cyc_d = 1'b0;
          flag_d    = 1'b1;
          ack_d     = 1'b1;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        usr_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q   <= ST_IDLE;
      usr_cyc_q <= 1'b0;
      usr_we_q  <= 1'b0;
      usr_sel_q <= '0;
      usr_adr_q <= '0;
      usr_dat_q <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      usr_cyc_q <= usr_cyc_d;
      usr_we_q  <= usr_we_d;
      usr_sel_q <= usr_sel_d;
      usr_adr_q <= usr_adr_d;
      usr_dat_q <= usr_dat_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      flag_q    <= flag_d;
    end
  end

  assign usr_cyc_o    = usr_cyc_q;
  assign usr_stb_o    = usr_cyc_q;
  assign usr_we_o     = usr_we_q;
  assign usr_sel_o    = usr_sel_q;
  assign usr_adr_o    = usr_adr_q;
  assign usr_dat_o    = usr_dat_q;
  assign mprj_ack_i   = ack_q;
  assign mprj_dat_i   = rdat_q;
  assign timeout_flag = flag_q;

`ifdef MPRJ_WB_GUARD_STATS_EN
  logic             tmo_evt;
  logic [15:0]      tcount_q, tcount_d;
  logic [ADR_W-1:0] tadr_q,   tadr_d;

  assign tmo_evt = (state_q == ST_REQ) && mprj_cyc_o && !usr_ack_i && tmo_tc;

  always_comb begin
    tcount_d = tcount_q;
    tadr_d   = tadr_q;
    if (tmo_evt) begin
      tadr_d = usr_adr_q;
      if (tcount_q != 16'hFFFF) begin
        tcount_d = tcount_q + 16'd1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      tcount_q <= '0;
      tadr_q   <= '0;
    end else begin
      tcount_q <= tcount_d;
      tadr_q   <= tadr_d;
    end
  end

  assign timeout_count    = tcount_q;
  assign last_timeout_adr = tadr_q;
`endif

endmodule

`default_nettype wire

// File: doc/mprj_wb_guard.md
Name: mprj_wb_guard

Overview:
- Sits directly downstream of the management core's exported user-project Wishbone master (mprj_* bus), between it and the user project area.
- Registers each request and re-issues it to the user side.
- Isolates the user side when the interface is disabled.
- Terminates any user transaction that never acks, so the CPU cannot hang on a dead or unpowered user project.

Parameters:
- TIMEOUT, 1024: cycles in REQ without usr_ack_i before forced termination; legal range 2..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on timeout.
- CW, $clog2(TIMEOUT+1): timeout counter width (derived; not overridden).

Ports:
- core_clk  in  1  single clock
- core_rstn  in  1  asynchronous active-low reset
- mprj_wb_iena  in  1  user interface enable from core
- mprj_cyc_o  in  1  core-side cycle
- mprj_stb_o  in  1  core-side strobe
- mprj_we_o  in  1  core-side write enable
- mprj_sel_o  in  4  core-side byte selects
- mprj_adr_o  in  32  core-side address
- mprj_dat_o  in  32  core-side write data
- mprj_ack_i  out  1  ack back to core
- mprj_dat_i  out  32  read data back to core
- usr_cyc_o  out  1  user-side cycle
- usr_stb_o  out  1  user-side strobe
- usr_we_o  out  1  user-side write enable
- usr_sel_o  out  4  user-side byte selects
- usr_adr_o  out  32  user-side address
- usr_dat_o  out  32  user-side write data
- usr_ack_i  in  1  user-side ack
- usr_dat_i  in  32  user-side read data
- timeout_flag  out  1  sticky; set on any timeout; cleared only by reset

Behaviour:
- Reset (async, core_rstn low): state IDLE, counter 0, all outputs 0, including data, address, sel, flag.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On mprj_cyc_o & mprj_stb_o & mprj_wb_iena: latch we/sel/adr/dat into usr_* registers, set usr_cyc_o = usr_stb_o = 1, clear counter, go to REQ.
  - On mprj_cyc_o & mprj_stb_o & !mprj_wb_iena: no user transaction; load mprj_dat_i = 0, go to RESP; flag unchanged.
- REQ:
  - Counter increments each cycle.
  - If usr_ack_i: capture usr_dat_i (writes: capture anyway, value is don't-care to the core), drop usr_cyc_o/usr_stb_o, go to RESP.
  - Else if counter == TIMEOUT-1: drop usr_cyc_o/usr_stb_o, load TIMEOUT_DATA, set timeout_flag, go to RESP.
  - usr_ack_i in the same cycle as the timeout condition: the ack wins; no flag.
  - mprj_cyc_o falls while in REQ (abort): drop usr_cyc_o/usr_stb_o, go to IDLE, no ack.
  - mprj_wb_iena falling during REQ is ignored; the transaction completes.
- RESP: mprj_ack_i = 1 for exactly one cycle with mprj_dat_i valid, then go to IDLE. mprj_dat_i holds its value until the next load.
- Latency:
  - Core strobe sampled at edge N gives usr_stb_o high from cycle N+1.
  - usr_ack_i sampled at edge M gives mprj_ack_i high in cycle M+1.
  - Minimum round trip (zero-wait user slave): 3 cycles from strobe to ack.
  - Timeout ack comes TIMEOUT cycles after entering REQ, plus 1.
- Back-to-back: a new request is accepted in the first IDLE cycle after RESP, since the core drops its strobe after sampling the ack.
- usr_* request fields are stable for the entire REQ state.
- usr_ack_i outside REQ is ignored.

Optional Feature:
- Macro MPRJ_WB_GUARD_STATS_EN.
- Defined: adds outputs timeout_count [15:0] and last_timeout_adr [31:0].
  - timeout_count is a saturating count of timeouts: holds at 16'hFFFF.
  - last_timeout_adr is the usr_adr_o of the most recent timeout.
  - Both reset to 0.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package mprj_wb_pkg:
  - state enum (IDLE/REQ/RESP)
  - default TIMEOUT_DATA constant
  - Wishbone field widths (ADR_W = 32, DAT_W = 32, SEL_W = 4)
- Sub-module mprj_wb_tmo_cnt: clearable counter with terminal-count output.
- FSM and datapath registers stay in the top module.

Test Plan:
- iena = 1, read adr 32'h3000_0004, user acks after 2 wait cycles with 32'h1234_5678 -> usr_stb_o high exactly 3 cycles; one mprj_ack_i pulse carrying 32'h1234_5678; flag 0.
- iena = 1, write adr 32'h3000_0000, dat 32'hA5A5_A5A5, sel 4'b0011 -> usr_* fields match exactly and stay stable until usr_ack_i; single ack back to the core.
- TIMEOUT = 16, user never acks -> usr_cyc_o drops after 16 REQ cycles; mprj_dat_i = 32'hDEAD_BEEF with a one-cycle ack; timeout_flag = 1 and stays set through a following good transaction.
- iena = 0, read -> usr_cyc_o never rises; ack returned 2 cycles after the strobe with data 0.
- usr_ack_i on exactly the timeout cycle -> user data returned; flag stays 0. Separately, core drops cyc mid-REQ -> no ack, state returns to IDLE.
- core_rstn pulsed low during REQ -> all outputs 0 asynchronously; the next request completes normally. With MPRJ_WB_GUARD_STATS_EN defined, 3 timeouts -> timeout_count = 3 and last_timeout_adr holds the third address.
